// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared encodings for the byte-lane data memory: access size
//            codes, lane count and the clear/run FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  // Access size encodings carried on req_size (2'b11 is illegal)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte lanes per 32-bit word
  localparam int C_NUM_LANES = 4;

  // Controller states: S_CLEAR only exists when the reset sweep is built in
  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_bytelane_if.sv
// ============================================================================
// Module   : dmem_bytelane_if
// Brief    : Request/response bundle between the CPU datapath (master) and
//            the byte-lane data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_bytelane_if;

  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] num_addr;
  logic [31:0] number;
  logic        req_ready;
  logic        rd_valid;
  logic [31:0] storage_out;
  logic        misalign_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, num_addr, number,
    input  req_ready, rd_valid, storage_out, misalign_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, num_addr, number,
    output req_ready, rd_valid, storage_out, misalign_err
  );

endinterface

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational lane logic: byte-enable mask, store data
//            replication, alignment check, and load lane extract with
//            sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [31:0] w_shifted;

  // Store side: which lanes get written, what data lands in each, and legality
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o       = 4'b0011 << lane_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = lane_i[0];
      end
      SZ_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |lane_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    w_shifted = rword_i >> {lane_i, 3'b000};
    case (size_i)
      SZ_BYTE: rdata_o = {{24{signed_i & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: rdata_o = {{16{signed_i & w_shifted[15]}}, w_shifted[15:0]};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_bytelane.sv
// ============================================================================
// Module   : dmem_bytelane
// Brief    : Parametrised 32-bit data memory with byte/half/word access,
//            byte-lane write merge, registered extended load with rd_valid
//            strobe, misalignment rejection and a req/ready handshake.
//            Optional macro CLEAR_ON_RST_EN adds a post-reset sweep writing
//            INIT_ZERO_VAL to every word while req_ready is held low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int          ADDR_W        = 10,
  parameter logic [31:0] INIT_ZERO_VAL = 32'h0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dmem_bytelane_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_misalign;
  logic [31:0]       w_rword;
  logic [31:0]       w_rdata;
  logic              w_ready;
  logic              w_accept;
  logic              w_store;
  logic              w_load;
  logic              w_reject;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  state_t            w_state;

  logic              rd_valid_q, rd_valid_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       storage_q,  storage_d;

  // Address bits above the word index alias; INIT_ZERO_VAL is idle without the sweep
  logic              w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.num_addr[31:ADDR_W+2], INIT_ZERO_VAL};

  assign w_idx  = bus.num_addr[ADDR_W+1:2];
  assign w_lane = bus.num_addr[1:0];

  dmem_lane_align u_align (
    .size_i     (bus.req_size),
    .lane_i     (w_lane),
    .signed_i   (bus.req_signed),
    .wdata_i    (bus.number),
    .rword_i    (w_rword),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .misalign_o (w_misalign),
    .rdata_o    (w_rdata)
  );

`ifdef CLEAR_ON_RST_EN
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Sweep state and word counter; reset always restarts the sweep from word 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk every word once, then hand over to normal operation
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    w_clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        w_clr_we  = 1'b1;
        clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_RUN;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign w_state   = state_q;
  assign w_clr_idx = clr_cnt_q;
`else
  // No sweep: the controller is permanently running
  assign w_state   = S_RUN;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  assign w_ready  = (w_state == S_RUN);
  assign w_accept = bus.req_valid & w_ready;
  assign w_reject = w_accept & w_misalign;
  assign w_store  = w_accept & ~w_misalign &  bus.req_write;
  assign w_load   = w_accept & ~w_misalign & ~bus.req_write;

  // Asynchronous read; the load result is captured at the accepting edge
  assign w_rword = mem_q[w_idx];

  // Storage array: sweep writes take the port, otherwise merge enabled lanes only
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[w_clr_idx] <= INIT_ZERO_VAL;
    end else if (w_store) begin
      for (int l = 0; l < C_NUM_LANES; l++) begin
        if (w_be[l]) begin
          mem_q[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
        end
      end
    end
  end

  // Response next-state: pulses follow the accepted request, data holds otherwise
  always_comb begin
    rd_valid_d = w_load;
    misalign_d = w_reject;
    storage_d  = storage_q;
    if (w_load) begin
      storage_d = w_rdata;
    end
  end

  // Response registers, cleared (and any pending pulse cancelled) by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      storage_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      misalign_q <= misalign_d;
      storage_q  <= storage_d;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.storage_out  = storage_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
// ============================================================================
// Module   : tb_dmem_bytelane
// Brief    : Self-checking bench for dmem_bytelane: directed vector table,
//            randomized traffic against a byte-array reference model, and
//            reset / clear-sweep sequences (CLEAR_ON_RST_EN builds ADDR_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_bytelane;
  import dmem_pkg::*;

`ifdef CLEAR_ON_RST_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif
  localparam int NWORDS = 2 ** AW;
  localparam int NBYTES = 4 * NWORDS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_bytelane_if bus ();

  dmem_bytelane #(.ADDR_W(AW), .INIT_ZERO_VAL(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: flat little-endian byte memory plus expected outputs
  logic [7:0]  bm [NBYTES];
  logic [31:0] exp_out = 32'h0;
  bit          exp_rv  = 1'b0;
  bit          exp_err = 1'b0;

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] d;
    bit          erv;
    bit          eerr;
    logic [31:0] eout;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (a % nbytes_of(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sgn, input logic [31:0] a);
    int     b = int'(a % NBYTES);
    int     n = nbytes_of(sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(bm[(b + i) % NBYTES]) << (8 * i);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b = int'(a % NBYTES);
    for (int i = 0; i < nbytes_of(sz); i++) bm[(b + i) % NBYTES] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic model_zero();
    for (int i = 0; i < NBYTES; i++) bm[i] = 8'h00;
  endtask

  // One request cycle: drive at negedge, model the accepting edge, sample #1 after
  task automatic drive(input bit v, input bit wr, input logic [1:0] sz, input bit sgn,
                       input logic [31:0] a, input logic [31:0] d);
    bit mis;
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.num_addr   = a;
    bus.number     = d;
    @(posedge clk);
    mis     = is_mis(sz, a);
    exp_rv  = v && !mis && !wr;
    exp_err = v && mis;
    if (v && !mis && wr) model_store(sz, a, d);
    if (exp_rv) exp_out = model_load(sz, sgn, a);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " rd_valid"},     {31'b0, bus.rd_valid},     {31'b0, exp_rv});
    check({tag, " misalign_err"}, {31'b0, bus.misalign_err}, {31'b0, exp_err});
    check({tag, " storage_out"},  bus.storage_out,           exp_out);
  endtask

  task automatic count_sweep(input string tag);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.num_addr   = 32'h0;
    bus.number     = 32'h0;

    // Directed vectors: {wr, size, signed, addr, data, rd_valid, misalign_err, storage_out}
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h13,   32'h77777780, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        1'b1, 1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        1'b1, 1'b0, 32'h00000080};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h80ADBEEF};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        1'b1, 1'b0, 32'h000080AD};
    tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        1'b1, 1'b0, 32'hFFFF80AD};
    tbl[8]  = '{1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        1'b1, 1'b0, 32'hFFFFFFBE};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h20,   32'hCAFEF00D, 1'b0, 1'b0, 32'hFFFFFFBE};
    tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h22,   32'hABCD1234, 1'b0, 1'b0, 32'hFFFFFFBE};
    tbl[11] = '{1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        1'b1, 1'b0, 32'h00001234};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1234F00D};
    tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h11,   32'h0,        1'b0, 1'b1, 32'h1234F00D};
    tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h21,   32'h00005555, 1'b0, 1'b1, 32'h1234F00D};
    tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        1'b1, 1'b0, 32'h1234F00D};
    tbl[16] = '{1'b1, 2'b10, 1'b0, 32'h1004, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h1234F00D};
    tbl[17] = '{1'b0, 2'b10, 1'b0, 32'h0004, 32'h0,        1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[18] = '{1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};

    // Asynchronous reset assertion clears every output immediately
    #1 rst = 1'b1;
    #2;
    check("reset rd_valid",     {31'b0, bus.rd_valid},     32'h0);
    check("reset misalign_err", {31'b0, bus.misalign_err}, 32'h0);
    check("reset storage_out",  bus.storage_out,           32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

`ifdef CLEAR_ON_RST_EN
    // Sweep: ready low for 16 cycles; a store held during it must be ignored
    check("sweep ready low", {31'b0, bus.req_ready}, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b10;
    bus.num_addr  = 32'h0;
    bus.number    = 32'hFFFFFFFF;
    count_sweep("sweep length");
    bus.req_valid = 1'b0;
    model_zero();
    for (int w = 0; w < NWORDS; w++) begin
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * w), 32'h0);
      check($sformatf("cleared word %0d", w), bus.storage_out, 32'h0);
    end
`else
    check("ready after reset", {31'b0, bus.req_ready}, 32'h1);
`endif

    // Directed table, applied back-to-back
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, tbl[i].wr, tbl[i].sz, tbl[i].sgn, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d rd_valid", i),     {31'b0, bus.rd_valid},     {31'b0, tbl[i].erv});
      check($sformatf("vec%0d misalign_err", i), {31'b0, bus.misalign_err}, {31'b0, tbl[i].eerr});
      check($sformatf("vec%0d storage_out", i),  bus.storage_out,           tbl[i].eout);
    end

    // Error pulse lasts one cycle and the held data stays put
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("err pulse end", {31'b0, bus.misalign_err}, 32'h0);
    check("idle hold out", bus.storage_out,           32'hA5A5A5A5);

    // Load pulse lasts one cycle
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("ld pulse", {31'b0, bus.rd_valid}, 32'h1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("ld pulse end", {31'b0, bus.rd_valid}, 32'h0);
    check("ld hold out",  bus.storage_out,       32'h80ADBEEF);

    // Fill the random window with known words
    for (int w = 0; w < 16; w++) begin
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom);
      check_model("init");
    end

    // Randomized traffic over words 0..15 with random aliasing high bits
    for (int i = 0; i < 300; i++) begin
      a = ($urandom & ~32'(NBYTES - 1)) | 32'($urandom_range(0, 63));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom);
      check_model("rand");
    end

    // Reset in the middle of a load response cancels the pulse
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check_model("pre-rst load");
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid rst rd_valid",    {31'b0, bus.rd_valid},     32'h0);
    check("mid rst storage_out", bus.storage_out,           32'h0);
    check("mid rst misalign",    {31'b0, bus.misalign_err}, 32'h0);
    exp_out = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef CLEAR_ON_RST_EN
    model_zero();
    count_sweep("sweep after mid rst");
`else
    check("ready after mid rst", {31'b0, bus.req_ready}, 32'h1);
`endif
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check_model("post-rst load");

`ifdef CLEAR_ON_RST_EN
    // Reset at sweep cycle 7 restarts the full 16-cycle sweep
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h13572468);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("sweep cycle 7 ready", {31'b0, bus.req_ready}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_sweep("sweep restart length");
    model_zero();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    check_model("restart cleared");
    check("restart cleared value", bus.storage_out, 32'h0);
`endif

    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised data memory for the single-cycle/multicycle CPU datapath; successor to the word-only data store.
- Adds byte/halfword/word access with byte-lane write merging and sign/zero-extended loads.
- Adds a registered read with a valid strobe, misalignment detection, and a request/ready handshake.
- Sits between the ALU address output and the writeback mux.

Parameters:
- ADDR_W, 10, word-index width; depth = 2**ADDR_W words of 32 bits.
- INIT_ZERO_VAL, 32'h0, value written to every word by the optional clear sweep.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  access request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- num_addr  in  32  byte address; word index = num_addr[ADDR_W+1:2], lane = num_addr[1:0]
- number  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_ready  out  1  block accepts a request this cycle
- rd_valid  out  1  one-cycle pulse, storage_out carries new load data
- storage_out  out  32  extended load result, held until the next accepted load
- misalign_err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset: async, active-high. All outputs clear on rst assertion: rd_valid=0, storage_out=0, misalign_err=0.
- req_ready after reset release:
  - 1 without CLEAR_ON_RST_EN.
  - 0 during the clear sweep with CLEAR_ON_RST_EN.
- Memory contents are not affected by rst unless CLEAR_ON_RST_EN is set.
- Accept condition: req_valid & req_ready. One access per cycle; no queueing.
- Alignment check:
  - half requires num_addr[0]=0; word requires num_addr[1:0]=0; size 11 is always illegal.
  - Violation: no memory write, no rd_valid; misalign_err=1 on the next cycle; storage_out unchanged.
- Store, byte-enable generation:
  - byte: be = 4'b0001 << lane, data replicated to all lanes.
  - half: be = 4'b0011 << lane.
  - word: be = 4'b1111.
  - Only enabled lanes are written; other lanes are preserved.
  - Write commits at the accepting edge; no rd_valid.
- Load:
  - Word is read at the accepting edge.
  - Lane extract, then extension by req_signed, captured into storage_out.
  - rd_valid=1 for exactly the next cycle. Latency = 1 cycle.
- Back-to-back: a load in cycle N+1 to the address stored in cycle N returns the merged new data.
- Address wrap: bits above ADDR_W+1 are ignored; addresses alias modulo 4*2**ADDR_W bytes.
- FSM, states S_CLEAR and S_RUN:
  - Without the feature, the state is constant S_RUN.
  - S_RUN: req_ready=1.
- rst mid-operation: any in-flight rd_valid/misalign_err pulse is cancelled; a clear sweep restarts from index 0.

Optional Feature:
- Macro: CLEAR_ON_RST_EN.
- Defined:
  - On rst deassert, the FSM enters S_CLEAR.
  - A clear counter walks word 0..2**ADDR_W-1, writing INIT_ZERO_VAL at one word per cycle.
  - req_ready=0 throughout; requests are ignored.
  - After the last word, transition to S_RUN with req_ready=1.
  - Total sweep = 2**ADDR_W cycles.
- Undefined: no counter, no S_CLEAR; memory holds its prior/initial contents; req_ready=1 from the first cycle after reset.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state typedef {S_CLEAR, S_RUN}.
  - Lane-count constant 4.
- Sub-module dmem_lane_align: combinational. Computes the be mask, replicated store data, the misalign flag, and load extract plus sign/zero extension.
- The top holds the array, FSM, clear counter and output registers.

Test Plan:
- Word store 32'hDEADBEEF at addr 0x10, then word load 0x10 -> rd_valid 1 cycle later, storage_out=32'hDEADBEEF.
- Byte store 8'h80 at 0x13 over that word, then byte loads:
  - lb signed 0x13 -> 32'hFFFFFF80.
  - lbu 0x13 -> 32'h00000080.
  - word load 0x10 -> 32'h80ADBEEF.
- Half store 16'h1234 at 0x22, then lh 0x22 -> 32'h00001234; lw 0x20 -> 32'h1234xxxx, low half unchanged.
- Misaligned access:
  - lw at 0x11 -> misalign_err pulse, no rd_valid, storage_out unchanged.
  - sh at 0x21 -> word 0x20 unchanged.
- Wrap: with ADDR_W=10, store 32'hA5A5A5A5 at 0x1004, load 0x0004 -> 32'hA5A5A5A5.
- CLEAR_ON_RST_EN with ADDR_W=4:
  - Pulse rst -> req_ready=0 for 16 cycles, then 1; all words read 0.
  - Reassert rst at sweep cycle 7 -> sweep restarts, 16 more cycles.
